// File: rtl/mult_rr_arbiter.sv
// mult_rr_arbiter: round-robin arbiter that shares a single WIDTH x WIDTH
// unsigned multiplier among NREQ requesters. Each lane hands over an operand
// pair with a valid/ready handshake. The product, and the index of the lane
// that produced it, go into a single-entry output register that has its own
// valid/ready handshake. Accepting while the result drains sustains one
// result per cycle.
module mult_rr_arbiter #(
    parameter int WIDTH = 3,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ*WIDTH-1:0] req_a_i,
    input  logic [NREQ*WIDTH-1:0] req_b_i,
    output logic [NREQ-1:0]       req_ready_o,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [2*WIDTH-1:0]    rsp_p_o,
    output logic [IDW-1:0]        rsp_id_o
);

    localparam logic [IDW-1:0] LAST_INIT = IDW'(NREQ - 1);

    // Output register and round-robin pointer
    logic                 rsp_valid_q, rsp_valid_d;
    logic [2*WIDTH-1:0]   rsp_p_q,     rsp_p_d;
    logic [IDW-1:0]       rsp_id_q,    rsp_id_d;
    logic [IDW-1:0]       last_grant_q, last_grant_d;

    // Arbitration results
    logic                 found;
    logic [IDW-1:0]       winner;
    logic                 can_accept;
    logic                 transfer;
    logic [WIDTH-1:0]     a_sel;
    logic [WIDTH-1:0]     b_sel;
    logic [2*WIDTH-1:0]   product;

    // Search req_valid from last_grant+1 and wrap modulo NREQ. The first set
    // bit wins.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so a
        // path that does not assign it cannot infer a latch.
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= NREQ; k++) begin
            automatic int idx = (int'(last_grant_q) + k) % NREQ;
            if (!found && req_valid_i[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    // A lane is accepted only when the output register is empty or is being
    // drained this cycle. Gating with rst_n keeps req_ready low during reset.
    assign can_accept = !rsp_valid_q || rsp_ready_i;
    assign transfer   = found && can_accept && rst_n;

    // Drive the one-hot ready to the winning lane.
    always_comb begin
        req_ready_o = '0;
        if (transfer) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    // Select the operands of the winning lane. Zero-extend them first so the
    // product is formed at the full 2*WIDTH width.
    assign a_sel   = req_a_i[winner*WIDTH +: WIDTH];
    assign b_sel   = req_b_i[winner*WIDTH +: WIDTH];
    assign product = (2*WIDTH)'(a_sel) * (2*WIDTH)'(b_sel);

    // Next state: load on transfer, clear valid on a drain with no refill,
    // otherwise hold.
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_p_d      = rsp_p_q;
        rsp_id_d     = rsp_id_q;
        last_grant_d = last_grant_q;
        if (transfer) begin
            rsp_valid_d  = 1'b1;
            rsp_p_d      = product;
            rsp_id_d     = winner;
            last_grant_d = winner;
        end else if (rsp_valid_q && rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers. Reset discards any pending result and points the
    // arbiter at NREQ-1, so that lane 0 has priority first.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: rsp_p and rsp_id are cleared on reset on purpose. The block
        // must present zeros on those outputs as soon as reset asserts.
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_p_q      <= '0;
            rsp_id_q     <= '0;
            last_grant_q <= LAST_INIT;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // register samples the values from before the edge.
            rsp_valid_q  <= rsp_valid_d;
            rsp_p_q      <= rsp_p_d;
            rsp_id_q     <= rsp_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_p_o     = rsp_p_q;
    assign rsp_id_o    = rsp_id_q;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Directed testbench for mult_rr_arbiter with WIDTH=3, NREQ=4. Inputs change
// 1 ns after a rising edge. Combinational ready is checked 1 ns after the
// inputs change. Registered outputs are checked 1 ns after the edge.
module tb_mult_rr_arbiter;

    localparam int WIDTH = 3;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2*WIDTH-1:0]    rsp_p;
    logic [IDW-1:0]        rsp_id;

    int n_vec = 0;
    int n_bad = 0;

    mult_rr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_p_o     (rsp_p),
        .rsp_id_o    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net: stop the run if it goes far past its expected length.
    initial begin
        #20000;
        $display("FAIL timeout: simulation ran past 20000 ns, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    int exp_id[5]   = '{0, 1, 2, 3, 0};
    int exp_prod[5] = '{2, 6, 15, 49, 2};

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // Reset state: outputs are zero, and ready stays low while rst_n is low.
        #3;
        check("reset_ready", 16'(req_ready), 16'd0);
        check("reset_valid", 16'(rsp_valid), 16'd0);
        check("reset_p",     16'(rsp_p),     16'd0);
        check("reset_id",    16'(rsp_id),    16'd0);
        tick();
        rst_n = 1'b1;
        req_valid = 4'b0000;
        tick();

        // Single lane: lane 2 sends 5*3.
        set_lane(2, 3'd5, 3'd3);
        req_valid = 4'b0100;
        #1;
        check("single_ready", 16'(req_ready), 16'b0100);
        tick();
        check("single_valid", 16'(rsp_valid), 16'd1);
        check("single_p",     16'(rsp_p),     16'd15);
        check("single_id",    16'(rsp_id),    16'd2);
        req_valid = 4'b0000;
        tick();
        check("single_drain", 16'(rsp_valid), 16'd0);

        // All lanes contend after reset: grants go 0,1,2,3,0.
        pulse_reset();
        tick();
        set_lane(0, 3'd1, 3'd2);
        set_lane(1, 3'd3, 3'd2);
        set_lane(2, 3'd5, 3'd3);
        set_lane(3, 3'd7, 3'd7);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("rr_ready%0d", k), 16'(req_ready), 16'(1 << exp_id[k]));
            tick();
            check($sformatf("rr_id%0d", k), 16'(rsp_id), 16'(exp_id[k]));
            check($sformatf("rr_p%0d", k),  16'(rsp_p),  16'(exp_prod[k]));
            check($sformatf("rr_v%0d", k),  16'(rsp_valid), 16'd1);
        end
        req_valid = 4'b0000;
        tick();

        // Backpressure: lane 1 sends 6*5, then the consumer stalls for 3 cycles.
        set_lane(1, 3'd6, 3'd5);
        set_lane(0, 3'd1, 3'd2);
        set_lane(3, 3'd2, 3'd3);
        req_valid = 4'b0010;
        tick();
        check("bp_p0",  16'(rsp_p),  16'd30);
        check("bp_id0", 16'(rsp_id), 16'd1);
        req_valid = 4'b1001;
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_ready%0d", k), 16'(req_ready), 16'd0);
            tick();
            check($sformatf("bp_valid%0d", k), 16'(rsp_valid), 16'd1);
            check($sformatf("bp_p%0d", k),     16'(rsp_p),     16'd30);
            check($sformatf("bp_id%0d", k),    16'(rsp_id),    16'd1);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_grant3", 16'(req_ready), 16'b1000);
        tick();
        check("bp_id3", 16'(rsp_id), 16'd3);
        check("bp_p3",  16'(rsp_p),  16'd6);
        #1;
        check("bp_grant0", 16'(req_ready), 16'b0001);
        tick();
        check("bp_idl0", 16'(rsp_id), 16'd0);
        check("bp_pl0",  16'(rsp_p),  16'd2);
        req_valid = 4'b0000;
        tick();

        // Extremes on lane 0: the full-width product is not truncated.
        req_valid = 4'b0001;
        set_lane(0, 3'd0, 3'd7);
        tick();
        check("ext_0x7", 16'(rsp_p), 16'd0);
        set_lane(0, 3'd7, 3'd0);
        tick();
        check("ext_7x0", 16'(rsp_p), 16'd0);
        set_lane(0, 3'd7, 3'd7);
        tick();
        check("ext_7x7", 16'(rsp_p), 16'd49);
        check("ext_id",  16'(rsp_id), 16'd0);
        req_valid = 4'b0000;
        tick();

        // Reset mid-operation: a result is pending and the consumer is stalled.
        set_lane(1, 3'd2, 3'd2);
        req_valid = 4'b0010;
        tick();
        check("mid_p_before", 16'(rsp_p), 16'd4);
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_valid", 16'(rsp_valid), 16'd0);
        check("mid_p",     16'(rsp_p),     16'd0);
        check("mid_id",    16'(rsp_id),    16'd0);
        #1;
        rst_n = 1'b1;
        req_valid = 4'b1001;
        rsp_ready = 1'b1;
        #1;
        check("mid_grant", 16'(req_ready), 16'b0001);
        tick();
        check("mid_id_after", 16'(rsp_id), 16'd0);
        check("mid_p_after",  16'(rsp_p),  16'd49);

        // Idle: lane 2 transfers, then no lane is valid for 5 cycles.
        set_lane(2, 3'd5, 3'd3);
        req_valid = 4'b0100;
        tick();
        check("idle_id", 16'(rsp_id), 16'd2);
        check("idle_p",  16'(rsp_p),  16'd15);
        req_valid = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("idle_valid%0d", k), 16'(rsp_valid), 16'd0);
        end
        req_valid = 4'b1111;
        #1;
        check("idle_grant", 16'(req_ready), 16'b1000);
        tick();
        check("idle_id3", 16'(rsp_id), 16'd3);
        check("idle_p3",  16'(rsp_p),  16'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
